motor_cmd_seq: RTL and testbench

- Command sequencer feeding the PWM motor controller's 11-bit signed lft/rht inputs.
- Accepts target wheel commands from the navigation logic and slew-limits each wheel toward its target at a fixed tick rate.
- Forces a zero-speed brake dwell before any direction reversal.
- Provides a latched emergency stop that drives both wheels to zero (brake) immediately.

---
 rtl/motor_pkg.sv | 16 +
 rtl/motor_slew.sv | 125 ++++++++++++
 rtl/motor_cmd_seq.sv | 101 ++++++++++
 tb/tb_motor_cmd_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor command sequencer.
//   CMD_W            : width of a signed wheel command
//   CMD_MAX/CMD_MIN  : symmetric command range (-1024 is never emitted)
//   slew_state_t     : per-wheel sequencer state
//   clamp_cmd()      : folds the one asymmetric code (-1024) onto CMD_MIN
package motor_pkg;
  localparam int CMD_W = 11;
  localparam logic signed [CMD_W-1:0] CMD_MAX = 11'sd1023;
  localparam logic signed [CMD_W-1:0] CMD_MIN = -11'sd1023;

  typedef enum logic [1:0] {IDLE, SLEW, DWELL} slew_state_t;

  function automatic logic signed [CMD_W-1:0] clamp_cmd(input logic signed [CMD_W-1:0] v);
    return (v < CMD_MIN) ? CMD_MIN : v;
  endfunction
endpackage

// File: rtl/motor_slew.sv
// Per-wheel slew limiter with brake dwell before a direction reversal.
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick        : one-cycle slew strobe
//   force_zero  : e-stop; output to 0 and FSM to IDLE at once
//   tgt         : latched signed target
//   cur         : registered signed command
//   at_tgt      : cur equals tgt
//   dwell_act   : holding at zero before a reversal
module motor_slew
  import motor_pkg::*;
#(
  parameter int STEP        = 32,
  parameter int DWELL_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    force_zero,
  input  logic signed [CMD_W-1:0] tgt,
  output logic signed [CMD_W-1:0] cur,
  output logic                    at_tgt,
  output logic                    dwell_act
);
  localparam int CNT_W = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;
  localparam logic signed [CMD_W:0] STEP_S = STEP[CMD_W:0];

  slew_state_t             state_q, state_d;
  logic signed [CMD_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]        dwell_cnt_q, dwell_cnt_d;
  logic                    last_dir_q, last_dir_d;  // 0 = forward, 1 = reverse

  logic signed [CMD_W:0]   cur_x, tgt_x, diff, toward_t, toward_zero, stepped;
  logic signed [CMD_W-1:0] step_cmd;
  logic                    opposite, rev_pend, next_rev;

  // One slew step computed in 12 bits so tgt - cur cannot overflow.
  always_comb begin
    cur_x = {cur_q[CMD_W-1], cur_q};
    tgt_x = {tgt[CMD_W-1], tgt};
    diff  = tgt_x - cur_x;
    if (diff <= STEP_S && diff >= -STEP_S)
      toward_t = tgt_x;
    else if (diff[CMD_W])
      toward_t = cur_x - STEP_S;
    else
      toward_t = cur_x + STEP_S;
    // Opposite-sign targets brake toward zero and stop exactly there.
    if (cur_x <= STEP_S && cur_x >= -STEP_S)
      toward_zero = '0;
    else if (cur_x[CMD_W])
      toward_zero = cur_x + STEP_S;
    else
      toward_zero = cur_x - STEP_S;
    opposite = (cur_q != '0) && (tgt != '0) && (cur_q[CMD_W-1] != tgt[CMD_W-1]);
    stepped  = opposite ? toward_zero : toward_t;
    step_cmd = stepped[CMD_W-1:0];
    rev_pend = (cur_q == '0) && (tgt != '0) && (tgt[CMD_W-1] != last_dir_q);
    next_rev = (step_cmd == '0) && (tgt != '0) && (tgt[CMD_W-1] != last_dir_q);
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    dwell_cnt_d = dwell_cnt_q;
    last_dir_d  = last_dir_q;
    if (force_zero) begin
      cur_d       = '0;
      state_d     = IDLE;
      dwell_cnt_d = '0;
    end else if (tick) begin
      unique case (state_q)
        DWELL: begin
          if (!rev_pend) begin
            // Target went to zero or back to the old direction: no brake needed.
            state_d     = IDLE;
            dwell_cnt_d = '0;
          end else if (int'(dwell_cnt_q) + 1 >= DWELL_TICKS) begin
            state_d     = SLEW;
            dwell_cnt_d = '0;
          end else begin
            dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cur_q == tgt) begin
            state_d = IDLE;
          end else if (state_q == IDLE && rev_pend && DWELL_TICKS > 0) begin
            // Sitting at zero but last moved the other way.
            state_d     = DWELL;
            dwell_cnt_d = '0;
          end else begin
            // SLEW at zero only happens right after a finished dwell.
            cur_d = step_cmd;
            if (step_cmd == tgt)
              state_d = IDLE;
            else if (next_rev && DWELL_TICKS > 0)
              state_d = DWELL;
            else
              state_d = SLEW;
          end
        end
      endcase
      if (cur_d != '0)
        last_dir_d = cur_d[CMD_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      dwell_cnt_q <= '0;
      last_dir_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      dwell_cnt_q <= dwell_cnt_d;
      last_dir_q  <= last_dir_d;
    end
  end

  assign cur       = cur_q;
  assign at_tgt    = (cur_q == tgt);
  assign dwell_act = (state_q == DWELL);
endmodule

// File: rtl/motor_cmd_seq.sv
// Motor command sequencer: captures target pairs, generates the slew tick,
// latches e-stop and drives two per-wheel slew limiters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   lft_tgt, rht_tgt    : signed targets; tgt_vld/tgt_rdy handshake
//   estop, estop_clr    : e-stop request (level) and clear (pulse)
//   lft, rht            : registered signed wheel commands
//   ramping             : a wheel is off target or dwelling
//   estop_act           : e-stop latched
module motor_cmd_seq
  import motor_pkg::*;
#(
  parameter int TICK_DIV    = 1024,
  parameter int STEP        = 32,
  parameter int DWELL_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [CMD_W-1:0] lft_tgt,
  input  logic signed [CMD_W-1:0] rht_tgt,
  input  logic                    tgt_vld,
  output logic                    tgt_rdy,
  input  logic                    estop,
  input  logic                    estop_clr,
  output logic signed [CMD_W-1:0] lft,
  output logic signed [CMD_W-1:0] rht,
  output logic                    ramping,
  output logic                    estop_act
);
  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TCNT_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic                    tick;
  logic                    estop_act_q, estop_act_d;
  logic                    accept, force_zero;
  logic signed [CMD_W-1:0] tgt_in [2];
  logic signed [CMD_W-1:0] tgt_q  [2];
  logic signed [CMD_W-1:0] tgt_d  [2];
  logic signed [CMD_W-1:0] cur    [2];
  logic                    at_tgt    [2];
  logic                    dwell_act [2];

  assign tgt_in[0] = lft_tgt;
  assign tgt_in[1] = rht_tgt;

  assign tick       = (tick_cnt_q == TCNT_W'(TICK_DIV - 1));
  assign tgt_rdy    = ~estop_act_q;
  // A same-cycle estop wins over a target offer.
  assign accept     = tgt_vld & tgt_rdy & ~estop;
  assign force_zero = estop | estop_act_q;

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TCNT_W'(1);
    if (estop)
      estop_act_d = 1'b1;
    else if (estop_clr)
      estop_act_d = 1'b0;
    else
      estop_act_d = estop_act_q;
    for (int i = 0; i < 2; i++) begin
      if (estop)
        tgt_d[i] = '0;
      else if (accept)
        tgt_d[i] = clamp_cmd(tgt_in[i]);
      else
        tgt_d[i] = tgt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      estop_act_q <= 1'b0;
      for (int i = 0; i < 2; i++) tgt_q[i] <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      estop_act_q <= estop_act_d;
      for (int i = 0; i < 2; i++) tgt_q[i] <= tgt_d[i];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_wheel
    motor_slew #(
      .STEP        (STEP),
      .DWELL_TICKS (DWELL_TICKS)
    ) u_slew (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .force_zero (force_zero),
      .tgt        (tgt_q[gi]),
      .cur        (cur[gi]),
      .at_tgt     (at_tgt[gi]),
      .dwell_act  (dwell_act[gi])
    );
  end

  assign lft       = cur[0];
  assign rht       = cur[1];
  assign ramping   = ~at_tgt[0] | ~at_tgt[1] | dwell_act[0] | dwell_act[1];
  assign estop_act = estop_act_q;
endmodule

// File: tb/tb_motor_cmd_seq.sv
module tb_motor_cmd_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic signed [10:0] lft_tgt, rht_tgt, lft, rht;
  logic tgt_vld, tgt_rdy, estop, estop_clr, ramping, estop_act;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int up_val [4]  = '{32, 64, 96, 100};
  int up_rmp [4]  = '{1, 1, 1, 0};
  int rev_l  [10] = '{68, 36, 4, 0, 0, 0, 0, 0, -32, -40};
  int rev_r  [10] = '{68, 36, 4, 0, 0, 0, 0, 0, 0, 0};
  int rev_rm [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  always #5 clk = ~clk;

  motor_cmd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_tgt   (lft_tgt),
    .rht_tgt   (rht_tgt),
    .tgt_vld   (tgt_vld),
    .tgt_rdy   (tgt_rdy),
    .estop     (estop),
    .estop_clr (estop_clr),
    .lft       (lft),
    .rht       (rht),
    .ramping   (ramping),
    .estop_act (estop_act)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lr(input string tag, input int l, input int r);
    check_val({tag, "_lft"}, int'(lft), l);
    check_val({tag, "_rht"}, int'(rht), r);
  endtask

  // Outputs are sampled on the falling edge; cyc counts rising edges since reset release.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic to_tick();
    do step(); while (cyc % 1024 != 0);
  endtask

  task automatic send(input int l, input int r);
    lft_tgt = 11'(l);
    rht_tgt = 11'(r);
    tgt_vld = 1'b1;
    step();
    tgt_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tgt_vld = 1'b0; estop = 1'b0; estop_clr = 1'b0;
    lft_tgt = '0; rht_tgt = '0;
    repeat (3) @(negedge clk);
    chk_lr("reset", 0, 0);
    check_val("reset_ramping", int'(ramping), 0);
    check_val("reset_estop_act", int'(estop_act), 0);
    check_val("reset_tgt_rdy", int'(tgt_rdy), 1);
    rst_n = 1'b1; cyc = 0;

    // Ramp up both wheels to 100.
    send(100, 100);
    for (int i = 0; i < 4; i++) begin
      to_tick();
      chk_lr($sformatf("up%0d", i), up_val[i], up_val[i]);
      check_val($sformatf("up%0d_ramping", i), int'(ramping), up_rmp[i]);
      if (i == 0) begin
        repeat (500) step();
        check_val("hold_between_ticks", int'(lft), 32);
      end
    end

    // Left reverses through a dwell, right brakes to zero.
    send(-40, 0);
    for (int i = 0; i < 10; i++) begin
      to_tick();
      chk_lr($sformatf("rev%0d", i), rev_l[i], rev_r[i]);
      check_val($sformatf("rev%0d_ramping", i), int'(ramping), rev_rm[i]);
    end

    // Retarget mid-ramp on the right wheel.
    send(-40, 96);
    to_tick(); check_val("rt_a", int'(rht), 32);
    to_tick(); check_val("rt_b", int'(rht), 64);
    to_tick(); check_val("rt_c", int'(rht), 96);
    send(-40, 500);
    send(-40, 50);
    to_tick(); check_val("rt_d", int'(rht), 64);
    to_tick(); check_val("rt_e", int'(rht), 50);
    check_val("rt_ramping", int'(ramping), 0);

    // -1024 is clamped to -1023.
    send(-1024, 50);
    to_tick(); check_val("clamp_t1", int'(lft), -72);
    repeat (28) to_tick();
    to_tick(); check_val("clamp_t30", int'(lft), -1000);
    to_tick(); check_val("clamp_t31", int'(lft), -1023);
    check_val("clamp_ramping", int'(ramping), 0);

    // Right wheel to 300.
    send(-1024, 300);
    repeat (7) to_tick();
    to_tick(); chk_lr("pre_estop", -1023, 300);

    // E-stop, with a competing target offer in the same cycle.
    repeat (3) step();
    estop = 1'b1; tgt_vld = 1'b1; lft_tgt = 11'sd10; rht_tgt = 11'sd10;
    step();
    tgt_vld = 1'b0;
    chk_lr("estop", 0, 0);
    check_val("estop_act", int'(estop_act), 1);
    check_val("estop_tgt_rdy", int'(tgt_rdy), 0);
    check_val("estop_ramping", int'(ramping), 0);
    estop_clr = 1'b1; step(); estop_clr = 1'b0;
    check_val("clr_ignored", int'(estop_act), 1);
    estop = 1'b0; step();
    check_val("estop_latched", int'(estop_act), 1);
    estop_clr = 1'b1; step(); estop_clr = 1'b0;
    check_val("clr_estop_act", int'(estop_act), 0);
    check_val("clr_tgt_rdy", int'(tgt_rdy), 1);
    chk_lr("clr", 0, 0);
    to_tick();
    chk_lr("after_clr_tick", 0, 0);
    check_val("after_clr_ramping", int'(ramping), 0);

    // Left last moved in reverse, so +64 must dwell at zero first.
    send(64, 0);
    to_tick();
    check_val("post_clr_dwell1", int'(lft), 0);
    check_val("post_clr_dwell1_ramping", int'(ramping), 1);
    to_tick();
    check_val("post_clr_dwell2", int'(lft), 0);

    // Asynchronous reset mid-dwell.
    repeat (100) step();
    rst_n = 1'b0;
    #1;
    chk_lr("async_rst", 0, 0);
    check_val("async_rst_ramping", int'(ramping), 0);
    check_val("async_rst_tgt_rdy", int'(tgt_rdy), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 0;
    send(64, 0);
    to_tick(); check_val("post_rst_a", int'(lft), 32);
    check_val("post_rst_a_ramping", int'(ramping), 1);
    to_tick(); check_val("post_rst_b", int'(lft), 64);
    check_val("post_rst_b_ramping", int'(ramping), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
